// File: rtl/prog_loader_if.sv
// prog_loader_if: serial input plus program-memory write and load status bundle
interface prog_loader_if;
  logic rx;
  logic prog_we;
  logic [10:0] prog_addr;
  logic [13:0] prog_data;
  logic cpu_rst;
  logic busy;
  logic done;
  logic err;
  modport master (input rx, output prog_we, prog_addr, prog_data, cpu_rst, busy, done, err);
  modport slave (output rx, input prog_we, prog_addr, prog_data, cpu_rst, busy, done, err);
endinterface

// File: rtl/prog_loader.sv
// prog_loader: UART 8N1 bootloader writing a checksummed word frame into program memory
module prog_loader #(
  parameter int CLKS_PER_BIT = 434
) (
  input logic clk,
  input logic rst,
  prog_loader_if.master bus
);
  localparam logic [11:0] FULL = 12'(CLKS_PER_BIT - 1);
  localparam logic [11:0] HALF = 12'(CLKS_PER_BIT / 2 - 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rstate_t;
  typedef enum logic [2:0] {IDLE, CNT_H, CNT_L, DATA_H, DATA_L, CHK, DONE, ERROR} state_t;
  logic rx_s1, rx_s2, rx_d;
  rstate_t rs;
  logic [11:0] tick;
  logic [2:0] nbit;
  logic [7:0] shreg;
  logic byte_ok, frame_err;
  state_t st;
  logic [3:0] cnt_h;
  logic [5:0] hi;
  logic [11:0] n, wcnt, n_next;
  logic [7:0] sum;
  always_comb n_next = {cnt_h, shreg};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rx_s1, rx_s2, rx_d} <= 3'b111;
      rs <= R_IDLE;
      tick <= '0;
      nbit <= '0;
      shreg <= '0;
      byte_ok <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_d <= rx_s2;
      byte_ok <= 1'b0;
      frame_err <= 1'b0;
      tick <= tick + 12'd1;
      case (rs)
        R_IDLE: begin
          tick <= '0;
          if (rx_d && !rx_s2) rs <= R_START;
        end
        R_START: if (tick == HALF) begin
          tick <= '0;
          nbit <= '0;
          rs <= rx_s2 ? R_IDLE : R_DATA;
        end
        R_DATA: if (tick == FULL) begin
          tick <= '0;
          shreg <= {rx_s2, shreg[7:1]};
          nbit <= nbit + 3'd1;
          if (nbit == 3'd7) rs <= R_STOP;
        end
        R_STOP: if (tick == FULL) begin
          rs <= R_IDLE;
          byte_ok <= rx_s2;
          frame_err <= !rx_s2;
        end
      endcase
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      st <= IDLE;
      cnt_h <= '0;
      hi <= '0;
      n <= '0;
      wcnt <= '0;
      sum <= '0;
      bus.prog_we <= 1'b0;
      bus.prog_addr <= '0;
      bus.prog_data <= '0;
      bus.cpu_rst <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.err <= 1'b0;
    end else begin
      bus.prog_we <= 1'b0;
      bus.done <= 1'b0;
      if (bus.prog_we) bus.prog_addr <= bus.prog_addr + 11'd1;
      if (st == DONE) st <= IDLE;
      else if (frame_err && st != IDLE && st != ERROR) begin
        st <= ERROR;
        bus.err <= 1'b1;
        bus.busy <= 1'b0;
      end else if (byte_ok) case (st)
        IDLE, ERROR: if (shreg == 8'hA5) begin
          st <= CNT_H;
          bus.cpu_rst <= 1'b1;
          bus.busy <= 1'b1;
          bus.err <= 1'b0;
          bus.prog_addr <= '0;
          sum <= '0;
        end
        CNT_H: begin
          cnt_h <= shreg[3:0];
          sum <= sum + shreg;
          st <= CNT_L;
        end
        CNT_L: begin
          sum <= sum + shreg;
          n <= n_next;
          wcnt <= '0;
          if (n_next == 12'd0 || n_next > 12'd2048) begin
            st <= ERROR;
            bus.err <= 1'b1;
            bus.busy <= 1'b0;
          end else st <= DATA_H;
        end
        DATA_H: begin
          hi <= shreg[5:0];
          sum <= sum + shreg;
          st <= DATA_L;
        end
        DATA_L: begin
          bus.prog_data <= {hi, shreg};
          bus.prog_we <= 1'b1;
          sum <= sum + shreg;
          wcnt <= wcnt + 12'd1;
          st <= (wcnt + 12'd1 == n) ? CHK : DATA_H;
        end
        CHK: if (shreg == sum) begin
          st <= DONE;
          bus.done <= 1'b1;
          bus.busy <= 1'b0;
          bus.cpu_rst <= 1'b0;
        end else begin
          st <= ERROR;
          bus.err <= 1'b1;
          bus.busy <= 1'b0;
        end
        default: ;
      endcase
    end
endmodule
